// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the two-source Ethernet TX frame arbiter.
// Optional watchdog truncation is enabled by ETH_TX_ARB_WATCHDOG_EN.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } arb_state_t;

  localparam int DEF_DATA_BITS = 64;
  localparam int DEF_MAX_BEATS = 190;
  localparam int ABORT_W       = 16;

endpackage

// File: rtl/eth_rr_arbiter2.sv
// Two-way round-robin pick; last = 1 means s1 was granted most recently.
module eth_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b00: gnt = 2'b00;
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: gnt = last ? 2'b01 : 2'b10;
    endcase
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular merge of DMA and control TX streams onto one MAC port.
// ETH_TX_ARB_WATCHDOG_EN adds beat-limit truncation and abort counting.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  localparam int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] s0_axis_tdata,
  input  logic [KEEP_BITS-1:0] s0_axis_tkeep,
  input  logic                 s0_axis_tlast,
  input  logic                 s0_axis_tuser,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic [DATA_BITS-1:0] s1_axis_tdata,
  input  logic [KEEP_BITS-1:0] s1_axis_tkeep,
  input  logic                 s1_axis_tlast,
  input  logic                 s1_axis_tuser,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [KEEP_BITS-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [ABORT_W-1:0]   abort_count
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, pick;
  logic       last_q, last_d;
  logic       own_sel, own_ready;
  logic       own_valid, own_last, own_user;
  logic [DATA_BITS-1:0] own_data;
  logic [KEEP_BITS-1:0] own_keep;
  logic       force_last;

  eth_rr_arbiter2 u_rr (
    .req  ({s1_axis_tvalid, s0_axis_tvalid}),
    .last (last_q),
    .gnt  (pick)
  );

  assign own_sel   = grant_q[1];
  assign own_valid = own_sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign own_last  = own_sel ? s1_axis_tlast  : s0_axis_tlast;
  assign own_user  = own_sel ? s1_axis_tuser  : s0_axis_tuser;
  assign own_data  = own_sel ? s1_axis_tdata  : s0_axis_tdata;
  assign own_keep  = own_sel ? s1_axis_tkeep  : s0_axis_tkeep;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [7:0] beat_q;
  logic       xfer_acc;

  // beat_q counts beats already accepted, so this flags beat MAX_BEATS
  assign force_last = (beat_q == 8'(MAX_BEATS - 1)) & ~own_last;
  assign xfer_acc   = (state_q == XFER) & own_valid & m_axis_tready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q      <= '0;
      abort_count <= '0;
    end else begin
      if (state_q == IDLE)
        beat_q <= '0;
      else if (xfer_acc)
        beat_q <= beat_q + 8'd1;
      if (xfer_acc && force_last && !(&abort_count))
        abort_count <= abort_count + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = |8'(MAX_BEATS);
  assign force_last  = 1'b0;
  assign abort_count = '0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    own_ready     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        own_ready     = m_axis_tready;
        m_axis_tvalid = own_valid;
        if (own_valid) begin
          m_axis_tdata = own_data;
          m_axis_tkeep = own_keep;
          m_axis_tlast = own_last | force_last;
          m_axis_tuser = own_user | force_last;
        end
        if (own_valid && m_axis_tready) begin
          if (own_last) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = own_sel;
          end else if (force_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        own_ready = 1'b1;
        if (own_valid && own_last) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = own_sel;
        end
      end
      default: state_d = IDLE;
    endcase
    s0_axis_tready = own_ready & grant_q[0];
    s1_axis_tready = own_ready & grant_q[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: directed frames, queue-based checks.
// Watchdog scenario runs only when ETH_TX_ARB_WATCHDOG_EN is defined.
module tb_eth_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] s0_tdata, s1_tdata, m_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep;
  logic        s0_tlast, s0_tuser, s0_tvalid, s0_tready;
  logic        s1_tlast, s1_tuser, s1_tvalid, s1_tready;
  logic        m_tlast, m_tuser, m_tvalid, m_tready;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] abort_count;
  bit          tog = 1'b0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  eth_tx_arbiter #(.DATA_BITS(64), .MAX_BEATS(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tkeep  (s0_tkeep),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tuser  (s0_tuser),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tkeep  (s1_tkeep),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tuser  (s1_tuser),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .grant          (grant),
    .busy           (busy),
    .abort_count    (abort_count)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(int src, int fr, int b);
    return 64'hA500_0000_0000_0000 | (64'(src) << 48)
         | (64'(fr) << 16) | 64'(b);
  endfunction

  task automatic push_frame(int src, int fr, int n);
    for (int b = 1; b <= n; b++)
      exp_q.push_back({mk(src, fr, b),
                       (b == n) ? 8'h0F : 8'hFF,
                       b == n, 1'b0});
  endtask

  task automatic push_trunc(int src, int fr, int lim);
    for (int b = 1; b <= lim; b++)
      exp_q.push_back({mk(src, fr, b), 8'hFF,
                       b == lim, b == lim});
  endtask

  task automatic drive(int src, logic v, logic [63:0] d,
                       logic [7:0] k, logic l);
    if (src == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tkeep = k;
      s0_tlast = l; s0_tuser = 1'b0;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tkeep = k;
      s1_tlast = l; s1_tuser = 1'b0;
    end
  endtask

  task automatic send(int src, int fr, int n);
    int t;
    for (int b = 1; b <= n; b++) begin
      drive(src, 1'b1, mk(src, fr, b),
            (b == n) ? 8'h0F : 8'hFF, b == n);
      t = 0;
      forever begin
        @(negedge clock);
        if ((src == 0) ? s0_tready : s1_tready) break;
        t++;
        if (t > 300) begin
          total++; bad++;
          $display("FAIL timeout src%0d beat%0d", src, b);
          drive(src, 1'b0, '0, '0, 1'b0);
          return;
        end
      end
      @(posedge clock); #1;
    end
    drive(src, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_last();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(m_tvalid && m_tready && m_tlast) && t < 300);
    if (t >= 300) begin
      total++; bad++;
      $display("FAIL timeout waiting for tlast");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_s0rdy", 64'(s0_tready), 0);
    chk("rst_s1rdy", 64'(s1_tready), 0);
    chk("rst_abort", 64'(abort_count), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // monitor: pops expected beats on every accepted output beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected beat got %0h", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.d);
            chk("beat_keep", 64'(m_tkeep), 64'(e.k));
            chk("beat_last", 64'(m_tlast), 64'(e.l));
            chk("beat_user", 64'(m_tuser), 64'(e.u));
          end
        end
        if (!m_tvalid) begin
          chk("idle_data", m_tdata, 0);
          chk("idle_side", 64'({m_tkeep, m_tuser}), 0);
        end
        if (grant == 2'b10)
          chk("s0_rdy_nonowner", 64'(s0_tready), 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (tog) m_tready = ~m_tready;
    end
  end

  initial begin
    reset = 1'b0;
    m_tready = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    #2;
    do_reset();

    // single 4-beat s0 frame
    push_frame(0, 1, 4);
    fork
      send(0, 1, 4);
      begin
        @(negedge clock);
        chk("t1_idle_grant", 64'(grant), 0);
        chk("t1_idle_valid", 64'(m_tvalid), 0);
        @(negedge clock);
        chk("t1_grant", 64'(grant), 1);
        chk("t1_busy", 64'(busy), 1);
        wait_last();
        @(negedge clock);
        chk("t1_end_grant", 64'(grant), 0);
        chk("t1_end_busy", 64'(busy), 0);
      end
    join

    // simultaneous requests out of reset
    do_reset();
    push_frame(0, 2, 3);
    push_frame(1, 3, 3);
    fork
      send(0, 2, 3);
      send(1, 3, 3);
      begin
        wait_last();
        @(negedge clock);
        chk("t2_bubble_valid", 64'(m_tvalid), 0);
        chk("t2_bubble_grant", 64'(grant), 0);
        @(negedge clock);
        chk("t2_s1_grant", 64'(grant), 2);
      end
    join
    push_frame(0, 4, 1);
    push_frame(1, 5, 1);
    fork
      send(0, 4, 1);
      send(1, 5, 1);
      begin
        @(negedge clock);
        @(negedge clock);
        chk("t2_tie2_grant", 64'(grant), 1);
      end
    join

    // s1 frame under a toggling sink
    push_frame(1, 6, 6);
    tog = 1'b1;
    send(1, 6, 6);
    tog = 1'b0;
    m_tready = 1'b1;

`ifdef ETH_TX_ARB_WATCHDOG_EN
    push_trunc(0, 7, 8);
    send(0, 7, 12);
    @(negedge clock);
    chk("t4_abort_count", 64'(abort_count), 1);
`endif

    // reset lands on beat 3 of a 5-beat frame
    push_frame(0, 8, 0);
    exp_q.push_back({mk(0, 8, 1), 8'hFF, 1'b0, 1'b0});
    exp_q.push_back({mk(0, 8, 2), 8'hFF, 1'b0, 1'b0});
    drive(0, 1'b1, mk(0, 8, 1), 8'hFF, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    drive(0, 1'b1, mk(0, 8, 2), 8'hFF, 1'b0);
    @(posedge clock); #1;
    drive(0, 1'b1, mk(0, 8, 3), 8'hFF, 1'b0);
    #1;
    chk("t5_pre_valid", 64'(m_tvalid), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(m_tvalid), 0);
    chk("t5_rst_grant", 64'(grant), 0);
    chk("t5_rst_s0rdy", 64'(s0_tready), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    drive(0, 1'b0, '0, '0, 1'b0);
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    push_frame(1, 9, 2);
    fork
      send(1, 9, 2);
      begin
        @(negedge clock);
        @(negedge clock);
        chk("t5_s1_grant", 64'(grant), 2);
      end
    join

    repeat (5) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
